// File: rtl/tdm_demux.sv
// Receive-side TDM demultiplexer: distributes a framed sample stream onto
// NUM_CH parallel channels, tracking frame alignment with a HUNT/LOCKED FSM.
module tdm_demux #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned SEL_W  = 2,
  parameter int unsigned NUM_CH = 2**SEL_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_sof,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [NUM_CH-1:0]        out_valid,
  output logic                     frame_done,
  output logic                     locked,
  output logic                     sync_err,
  output logic [7:0]               err_cnt
);

  typedef enum logic [0:0] {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e                   state_q, state_d;
  logic [SEL_W-1:0]         slot_q, slot_d;
  logic [NUM_CH*DATA_W-1:0] out_data_q, out_data_d;
  logic [NUM_CH-1:0]        out_valid_q, out_valid_d;
  logic                     frame_done_q, frame_done_d;
  logic                     sync_err_q, sync_err_d;
  logic [7:0]               err_cnt_q, err_cnt_d;
  logic                     err_evt;

  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    out_data_d   = out_data_q;
    out_valid_d  = '0;
    frame_done_d = 1'b0;
    err_evt      = 1'b0;

    if (in_valid) begin
      if (state_q == HUNT) begin
        if (in_sof) begin
          out_data_d[0 +: DATA_W] = in_data;
          out_valid_d[0]          = 1'b1;
          slot_d                  = SEL_W'(1);
          state_d                 = LOCKED;
        end
      end else if (in_sof) begin
        // SOF always restarts the frame; arriving off slot 0 is an early-SOF resync
        err_evt                 = (slot_q != '0);
        out_data_d[0 +: DATA_W] = in_data;
        out_valid_d[0]          = 1'b1;
        slot_d                  = SEL_W'(1);
      end else if (slot_q == '0) begin
        err_evt = 1'b1;
        state_d = HUNT;
        slot_d  = '0;
      end else begin
        out_data_d[slot_q*DATA_W +: DATA_W] = in_data;
        out_valid_d[slot_q]                 = 1'b1;
        frame_done_d                        = (slot_q == '1);
        slot_d                              = slot_q + SEL_W'(1);
      end
    end

    sync_err_d = err_evt;
    err_cnt_d  = err_cnt_q;
    if (err_evt && err_cnt_q != 8'hFF) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= HUNT;
      slot_q       <= '0;
      out_data_q   <= '0;
      out_valid_q  <= '0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
      sync_err_q   <= sync_err_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign frame_done = frame_done_q;
  assign locked     = (state_q == LOCKED);
  assign sync_err   = sync_err_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_tdm_demux.sv
// Self-checking bench for tdm_demux: directed beats, a frame-level reference
// model compared every cycle, plus literal spot checks.
module tb_tdm_demux;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned NUM_CH = 4;

  logic                     clk = 1'b0;
  logic                     clk_en = 1'b1;
  logic                     rst_n = 1'b0;
  logic                     in_valid = 1'b0;
  logic [DATA_W-1:0]        in_data = '0;
  logic                     in_sof = 1'b0;
  logic [NUM_CH*DATA_W-1:0] out_data;
  logic [NUM_CH-1:0]        out_valid;
  logic                     frame_done;
  logic                     locked;
  logic                     sync_err;
  logic [7:0]               err_cnt;

  int checks   = 0;
  int failures = 0;

  // reference model state
  bit        m_locked;
  int        m_slot;
  int        m_err;
  bit [7:0]  m_ch [NUM_CH];
  bit [3:0]  m_ov;
  bit        m_fd;
  bit        m_se;

  tdm_demux #(.DATA_W(DATA_W), .SEL_W(SEL_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_sof(in_sof), .out_data(out_data), .out_valid(out_valid),
    .frame_done(frame_done), .locked(locked), .sync_err(sync_err),
    .err_cnt(err_cnt)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_slot = 0; m_err = 0; m_ov = 0; m_fd = 0; m_se = 0;
    foreach (m_ch[i]) m_ch[i] = 8'h00;
  endtask

  task automatic model_step(input bit v, input bit s, input bit [7:0] d);
    m_ov = 0; m_fd = 0; m_se = 0;
    if (!v) return;
    if (!m_locked) begin
      if (s) begin
        m_ch[0] = d; m_ov = 4'b0001; m_slot = 1; m_locked = 1;
      end
    end else if (s) begin
      if (m_slot != 0) begin
        m_se = 1; m_err = (m_err < 255) ? m_err + 1 : 255;
      end
      m_ch[0] = d; m_ov = 4'b0001; m_slot = 1;
    end else if (m_slot == 0) begin
      m_se = 1; m_err = (m_err < 255) ? m_err + 1 : 255; m_locked = 0;
    end else begin
      m_ch[m_slot] = d;
      m_ov = 4'(1 << m_slot);
      m_fd = (m_slot == NUM_CH - 1);
      m_slot = (m_slot + 1) % NUM_CH;
    end
  endtask

  task automatic check_all();
    logic [NUM_CH*DATA_W-1:0] exp_data;
    for (int k = 0; k < NUM_CH; k++) exp_data[k*DATA_W +: DATA_W] = m_ch[k];
    chk("out_data", 64'(out_data), 64'(exp_data));
    chk("out_valid", 64'(out_valid), 64'(m_ov));
    chk("frame_done", 64'(frame_done), 64'(m_fd));
    chk("locked", 64'(locked), 64'(m_locked));
    chk("sync_err", 64'(sync_err), 64'(m_se));
    chk("err_cnt", 64'(err_cnt), 64'(m_err));
  endtask

  // drive one cycle, advance the model, compare #1 after the edge
  task automatic beat(input bit v, input bit s, input bit [7:0] d);
    in_valid = v; in_sof = s; in_data = d;
    @(posedge clk);
    model_step(v, s, d);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; in_sof = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #2;
    check_all();
    chk("reset_out_data_lit", 64'(out_data), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // basic frame
    beat(1, 1, 8'h11);
    chk("lock_after_sof_lit", 64'(locked), 64'h1);
    beat(1, 0, 8'h22);
    beat(1, 0, 8'h33);
    beat(1, 0, 8'h44);
    chk("frame_done_lit", 64'(frame_done), 64'h1);
    chk("out_valid3_lit", 64'(out_valid), 64'h8);
    beat(0, 0, 8'h00);
    chk("frame1_data_lit", 64'(out_data), 64'h44332211);

    // beats before any SOF are discarded
    do_reset();
    beat(1, 0, 8'hAA);
    beat(1, 0, 8'hBB);
    chk("hunt_discard_lit", 64'(out_valid), 64'h0);
    beat(1, 1, 8'h01);
    beat(1, 0, 8'h02);
    beat(1, 0, 8'h03);
    beat(1, 0, 8'h04);
    beat(0, 0, 8'h00);
    chk("frame2_data_lit", 64'(out_data), 64'h04030201);

    // early SOF at slot 2
    beat(1, 1, 8'h10);
    beat(1, 0, 8'h20);
    beat(1, 1, 8'h5A);
    chk("early_sof_err_lit", 64'(sync_err), 64'h1);
    chk("early_sof_cnt_lit", 64'(err_cnt), 64'h1);
    beat(1, 0, 8'h66);
    chk("resync_data_lit", 64'(out_data), 64'h0403665A);
    beat(1, 0, 8'h77);
    beat(1, 0, 8'h88);

    // missing SOF at slot 0, then re-lock
    beat(1, 0, 8'h99);
    chk("missing_sof_err_lit", 64'(sync_err), 64'h1);
    beat(0, 0, 8'h00);
    chk("unlocked_lit", 64'(locked), 64'h0);
    beat(1, 1, 8'hC0);
    beat(0, 0, 8'h00);
    chk("relock_lit", 64'(locked), 64'h1);

    // gaps inside a frame
    do_reset();
    beat(1, 1, 8'h11);
    beat(0, 0, 8'hEE);
    beat(0, 0, 8'hEE);
    beat(1, 0, 8'h22);
    beat(1, 0, 8'h33);
    beat(0, 0, 8'hEE);
    beat(1, 0, 8'h44);
    beat(0, 0, 8'h00);
    chk("gap_frame_data_lit", 64'(out_data), 64'h44332211);

    // error counter saturation
    for (int n = 0; n < 300; n++) begin
      beat(1, 1, 8'(n));
      beat(1, 0, 8'h01);
      beat(1, 0, 8'h02);
      beat(1, 0, 8'h03);
      beat(1, 0, 8'h04);
    end
    chk("err_sat_lit", 64'(err_cnt), 64'd255);

    // async reset mid-frame with clock stopped
    beat(1, 1, 8'h31);
    beat(1, 0, 8'h32);
    @(negedge clk);
    clk_en = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("async_rst_err_cnt_lit", 64'(err_cnt), 64'h0);
    #5;
    rst_n = 1'b1;
    #5;
    clk_en = 1'b1;
    beat(1, 0, 8'h55);
    chk("post_rst_hunt_lit", 64'(out_valid), 64'h0);
    beat(1, 1, 8'h66);
    chk("post_rst_lock_lit", 64'(locked), 64'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout: sim time %0t exceeded limit", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Receive-side counterpart of the channel multiplexers: takes one time-division-multiplexed sample stream and distributes it back onto NUM_CH parallel channels.
- Each frame is NUM_CH consecutive valid beats. Slot 0 is marked by in_sof.
- Tracks frame alignment with a two-state lock FSM and a slot counter, flags alignment errors, and holds the last sample per channel.

Parameters:
- DATA_W, 8, width of one sample
- SEL_W, 2, slot index width; NUM_CH = 2**SEL_W channels (default 4)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  beat qualifier; a beat is consumed on every clk edge where in_valid=1 (no backpressure)
- in_data  in  DATA_W  sample for the current slot
- in_sof  in  1  start-of-frame; meaningful only when in_valid=1
- out_data  out  NUM_CH*DATA_W  channel k sample in bits [k*DATA_W +: DATA_W], held until overwritten
- out_valid  out  NUM_CH  one-cycle pulse on bit k when channel k is updated
- frame_done  out  1  one-cycle pulse when slot NUM_CH-1 is written while LOCKED
- locked  out  1  high while FSM is in LOCKED
- sync_err  out  1  one-cycle pulse on an alignment error
- err_cnt  out  8  count of sync_err events, saturates at 255

Behaviour:
- Reset (rst_n=0, asynchronous, may occur mid-frame):
  - state=HUNT, slot=0.
  - out_data=0, out_valid=0, frame_done=0, locked=0, sync_err=0, err_cnt=0.
- All outputs are registered. A beat sampled at edge N is visible after edge N (latency 1 cycle). Pulses last exactly one cycle.
- in_valid=0: no state change; all pulse outputs are 0 next cycle; out_data holds.
- State HUNT:
  - Valid beat with in_sof=0: discarded, no outputs change, no error.
  - Valid beat with in_sof=1: in_data written to channel 0, out_valid[0] pulses, slot<=1, state<=LOCKED.
- State LOCKED, valid beat, current slot s:
  - in_sof=0 and s!=0: write channel s, pulse out_valid[s], slot<=s+1 mod NUM_CH. If s=NUM_CH-1, also pulse frame_done.
  - in_sof=1 and s=0: normal frame start; write channel 0, pulse out_valid[0], slot<=1.
  - in_sof=1 and s!=0 (early SOF): pulse sync_err, err_cnt+1 (saturating), resync by writing channel 0 and pulsing out_valid[0], slot<=1. Stay LOCKED. No frame_done.
  - in_sof=0 and s=0 (missing SOF): pulse sync_err, err_cnt+1 (saturating), beat discarded (no out_valid), state<=HUNT, slot<=0.
- NUM_CH=2**SEL_W, so the slot counter wraps naturally; no other wrap cases exist.
- locked reflects the registered state: it rises the cycle after the locking SOF and falls the cycle after a missing-SOF error.
- err_cnt at 255 stays at 255; sync_err still pulses.
- Back-to-back valid beats are sustained indefinitely; throughput is 1 beat/cycle.

Test Plan:
- Reset, then 4 consecutive beats with in_sof on the first, data 0x11,0x22,0x33,0x44 → locked=1 after beat 1; out_valid pulses 0001,0010,0100,1000 on consecutive cycles; out_data=0x44332211; frame_done pulses once, aligned with out_valid[3].
- Beats 0xAA,0xBB with in_sof=0 before any SOF, then SOF frame 1..4 → the first two beats are ignored (no out_valid, no sync_err); the channels then hold 1,2,3,4.
- While locked, SOF arrives at slot 2 carrying 0x5A → sync_err pulse, err_cnt=1, channel 0=0x5A, next beat lands in channel 1; channels 2 and 3 keep their old values.
- While locked, a beat with in_sof=0 arrives when slot=0 → sync_err pulse, err_cnt+1, locked=0 next cycle, no out_valid; a following SOF re-locks.
- Frame with in_valid gaps (valid pattern 1,0,0,1,1,0,1) → same channel mapping and out_data as the gapless case; no pulses in idle cycles.
- 300 missing-SOF errors → err_cnt stops at 255. Assert rst_n=0 mid-frame with clk stopped → all outputs 0 immediately; after release, the block is in HUNT.
